// File: rtl/cnt_event_logger.sv
// Wrap and status-change event detector feeding a small record FIFO.
// Records are drained by a valid/ready consumer; drops set a sticky flag.
module cnt_event_logger #(
  parameter int DEPTH  = 4,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cnt_in,
  input  logic [1:0]        cc_in,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [15:0]       evt_data,
  output logic [WRAP_W-1:0] wraps,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [7:0]        r_prev_cnt;
  logic [1:0]        r_prev_cc;
  logic              r_prev_valid;
  logic [WRAP_W-1:0] r_wraps;
  logic              r_ovf;
  logic [PW-1:0]     r_wr;
  logic [PW-1:0]     r_rd;
  logic [15:0]       r_mem [DEPTH];

  logic              w_wrap;
  logic              w_cc;
  logic              w_evt;
  logic [WRAP_W-1:0] w_wraps_nxt;
  logic [15:0]       w_rec;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;

  // Only an exact FF->00 step is a wrap; larger jumps are ignored.
  assign w_wrap = !rst && r_prev_valid &&
                  (r_prev_cnt == 8'hFF) && (cnt_in == 8'h00);
  assign w_cc   = !rst && r_prev_valid && (cc_in != r_prev_cc);
  assign w_evt  = w_wrap || w_cc;

  assign w_wraps_nxt = r_wraps + WRAP_W'(w_wrap);
  assign w_rec = {w_cc, w_wrap, cc_in, w_wraps_nxt[3:0], cnt_in};

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) &&
                   (r_wr[AW] != r_rd[AW]);

  // A pop frees the slot the same-cycle push needs when full.
  assign w_pop  = !rst && !w_empty && evt_ready;
  assign w_push = w_evt && (!w_full || w_pop);
  assign w_drop = w_evt && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_cnt   <= 8'h00;
      r_prev_cc    <= 2'b00;
      r_prev_valid <= 1'b0;
      r_wraps      <= '0;
      r_ovf        <= 1'b0;
      r_wr         <= '0;
      r_rd         <= '0;
    end else begin
      r_prev_cnt   <= cnt_in;
      r_prev_cc    <= cc_in;
      r_prev_valid <= 1'b1;
      r_wraps      <= w_wraps_nxt;
      if (w_drop) r_ovf <= 1'b1;
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_rec;
  end

  assign evt_valid = !w_empty;
  assign evt_data  = r_mem[r_rd[AW-1:0]];
  assign wraps     = r_wraps;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_cnt_event_logger.sv
// Directed bench for cnt_event_logger at DEPTH=4, WRAP_W=8.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_cnt_event_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cnt_in;
  logic [1:0]  cc_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_data;
  logic [7:0]  wraps;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  cnt_event_logger #(.DEPTH(4), .WRAP_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cc_in     (cc_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_data  (evt_data),
    .wraps     (wraps),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cnt_in = 8'hFF; cc_in = 2'b00; evt_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(evt_valid), 32'd0);
    chk("rst_wraps", 32'(wraps), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);

    // release with 00: first edge only loads prev
    rst = 1'b0; cnt_in = 8'h00;
    step();
    chk("rel_valid", 32'(evt_valid), 32'd0);
    chk("rel_wraps", 32'(wraps), 32'd0);
    step();
    chk("rel2_valid", 32'(evt_valid), 32'd0);

    // plain wrap
    evt_ready = 1'b1;
    cnt_in = 8'hFE; step();
    cnt_in = 8'hFF; step();
    chk("pre_wrap_valid", 32'(evt_valid), 32'd0);
    cnt_in = 8'h00; step();
    chk("wrap_valid", 32'(evt_valid), 32'd1);
    chk("wrap_data", 32'(evt_data), 32'h4100);
    chk("wrap_cnt", 32'(wraps), 32'd1);
    cnt_in = 8'h01; step();
    chk("wrap_popped", 32'(evt_valid), 32'd0);

    // wrap and cc change together
    cnt_in = 8'hFF; step();
    cnt_in = 8'h00; cc_in = 2'b10; step();
    chk("both_valid", 32'(evt_valid), 32'd1);
    chk("both_data", 32'(evt_data), 32'hE200);
    chk("both_wraps", 32'(wraps), 32'd2);
    cnt_in = 8'h01; step();
    chk("both_single", 32'(evt_valid), 32'd0);

    // overflow: 5 cc toggles with consumer stalled
    evt_ready = 1'b0;
    cnt_in = 8'h10; cc_in = 2'b11; step();
    chk("ov_first", 32'(evt_data), 32'hB210);
    cnt_in = 8'h11; cc_in = 2'b10; step();
    cnt_in = 8'h12; cc_in = 2'b11; step();
    cnt_in = 8'h13; cc_in = 2'b10; step();
    chk("ov_full_valid", 32'(evt_valid), 32'd1);
    chk("ov_full_head", 32'(evt_data), 32'hB210);
    chk("ov_not_yet", 32'(overflow), 32'd0);
    cnt_in = 8'h14; cc_in = 2'b11; step();
    chk("ov_set", 32'(overflow), 32'd1);
    chk("ov_head_stable", 32'(evt_data), 32'hB210);
    step();
    chk("ov_stall_stable", 32'(evt_data), 32'hB210);
    evt_ready = 1'b1;
    step();
    chk("ov_pop1", 32'(evt_data), 32'hA211);
    step();
    chk("ov_pop2", 32'(evt_data), 32'hB212);
    step();
    chk("ov_pop3", 32'(evt_data), 32'hA213);
    chk("ov_pop3_valid", 32'(evt_valid), 32'd1);
    step();
    chk("ov_drained", 32'(evt_valid), 32'd0);
    chk("ov_sticky", 32'(overflow), 32'd1);

    // reset with three records queued
    evt_ready = 1'b0;
    cc_in = 2'b00; step();
    cc_in = 2'b11; step();
    cc_in = 2'b00; step();
    chk("mq_valid", 32'(evt_valid), 32'd1);
    rst = 1'b1; step();
    chk("mq_rst_valid", 32'(evt_valid), 32'd0);
    chk("mq_rst_wraps", 32'(wraps), 32'd0);
    chk("mq_rst_ovf", 32'(overflow), 32'd0);
    rst = 1'b0; step();
    chk("mq_rel_valid", 32'(evt_valid), 32'd0);
    cnt_in = 8'h20; cc_in = 2'b01; step();
    chk("mq_next_valid", 32'(evt_valid), 32'd1);
    chk("mq_next_data", 32'(evt_data), 32'h9020);

    // fill to four, then push and pop in one cycle
    cnt_in = 8'h21; cc_in = 2'b00; step();
    cnt_in = 8'h22; cc_in = 2'b01; step();
    cnt_in = 8'h23; cc_in = 2'b00; step();
    chk("fp_head", 32'(evt_data), 32'h9020);
    evt_ready = 1'b1;
    cnt_in = 8'h24; cc_in = 2'b01; step();
    chk("fp_ovf", 32'(overflow), 32'd0);
    chk("fp_head2", 32'(evt_data), 32'h8021);
    step();
    chk("fp_pop2", 32'(evt_data), 32'h9022);
    step();
    chk("fp_pop3", 32'(evt_data), 32'h8023);
    step();
    chk("fp_pop4", 32'(evt_data), 32'h9024);
    chk("fp_pop4_valid", 32'(evt_valid), 32'd1);
    step();
    chk("fp_empty", 32'(evt_valid), 32'd0);
    chk("fp_ovf_end", 32'(overflow), 32'd0);

    // ready while empty, then a wrap after a jump-only sequence
    step();
    chk("empty_idle", 32'(evt_valid), 32'd0);
    cnt_in = 8'hFF; step();
    cnt_in = 8'h00; step();
    chk("w2_data", 32'(evt_data), 32'h5100);
    chk("w2_wraps", 32'(wraps), 32'd1);
    cnt_in = 8'hFE; step();
    chk("jump_pop", 32'(evt_valid), 32'd0);
    cnt_in = 8'h00; step();
    chk("jump_no_evt", 32'(evt_valid), 32'd0);
    chk("jump_wraps", 32'(wraps), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnt_event_logger.md
CNT_EVENT_LOGGER -- requirements
Module: cnt_event_logger

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, event FIFO depth (power of two, 2..16).
REQ-002 The block SHALL have parameter WRAP_W, default 8, width of the wrap counter.
REQ-003 The block SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 The block SHALL have port cnt_in, input, 8, counter value from the upstream 8-bit counter stage, sampled every cycle.
REQ-006 The block SHALL have port cc_in, input, 2, upstream 2-bit status word, sampled every cycle.
REQ-007 The block SHALL have port evt_valid, output, 1, FIFO head holds a record.
REQ-008 The block SHALL have port evt_ready, input, 1, consumer accepts the head record.
REQ-009 The block SHALL have port evt_data, output, 16, head record {type[1:0], cc[1:0], wrapcnt[3:0], cnt[7:0]}.
REQ-010 The block SHALL have port wraps, output, WRAP_W, running count of detected wraps.
REQ-011 The block SHALL have port overflow, output, 1, sticky flag set when a record was dropped.

Function
REQ-012 The block SHALL register cnt_in and cc_in each cycle into prev_cnt and prev_cc, plus a prev_valid flag that is set on the first non-reset cycle.
REQ-013 The block SHALL detect a wrap event when prev_valid=1, prev_cnt=8'hFF and cnt_in=8'h00; no other transition counts as a wrap, including a jump such as 8'hFE to 8'h00.
REQ-014 The block SHALL detect a cc event when prev_valid=1 and cc_in differs from prev_cc.
REQ-015 The block SHALL encode type as 2'b01 for wrap only, 2'b10 for cc only and 2'b11 for both in the same cycle; both events in one cycle SHALL produce exactly one record.
REQ-016 The record SHALL carry cc=cc_in, cnt=cnt_in and wrapcnt = the low 4 bits of wraps after this cycle's increment.
REQ-017 On a wrap event, wraps SHALL increment by 1 modulo 2^WRAP_W, whether or not the record is stored.
REQ-018 A record detected at rising edge k SHALL be written into the FIFO at edge k; if the FIFO was empty, evt_valid SHALL be 1 and evt_data SHALL show the record in the cycle after edge k (one-cycle latency).
REQ-019 The FIFO SHALL use a valid/ready handshake: a pop occurs on an edge where evt_valid=1 and evt_ready=1; evt_data and evt_valid SHALL remain stable while evt_valid=1 and evt_ready=0.
REQ-020 The FIFO SHALL use DEPTH entries with read/write pointers one bit wider than log2(DEPTH), wrapping modulo 2*DEPTH; full when the low bits match and the MSBs differ, empty when the pointers are equal.
REQ-021 When full with no pop, a new record SHALL be dropped, overflow SHALL be set, and the FIFO contents SHALL be left unchanged.
REQ-022 When full and a pop occurs in the same cycle as a new record, both SHALL take effect, the record SHALL NOT be dropped, and overflow SHALL NOT be set.
REQ-023 When empty, evt_ready SHALL be ignored and no pointer SHALL move.
REQ-024 Once set, overflow SHALL remain 1 until reset.
REQ-025 evt_data SHALL be the FIFO entry at the read pointer; its value while evt_valid=0 is don't-care.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL clear the pointers, prev_valid, prev_cnt, prev_cc, wraps and overflow; evt_valid SHALL be 0 in the cycle after that edge.
REQ-027 An edge with rst=1 SHALL NOT detect or store any event, and the first edge after reset release SHALL only load prev_*, so no event can be produced before the second post-reset edge.
REQ-028 Reset asserted mid-operation SHALL discard all queued records without producing a handshake.

Verification
REQ-029 The bench SHALL cover a wrap: cnt_in 8'hFE,8'hFF,8'h00 with cc_in=2'b00 and evt_ready=1 -> one record 16'h4100 (type 01, wrapcnt 1) one cycle after the 8'h00 sample; wraps=1.
REQ-030 The bench SHALL cover simultaneous events: 8'hFF->8'h00 with cc_in 2'b00->2'b10 -> a single record with type 2'b11, cc 2'b10, cnt 8'h00.
REQ-031 The bench SHALL cover overflow: evt_ready=0 with 5 cc toggles at DEPTH=4 -> 4 records held in order, overflow=1, 5th dropped; then evt_ready=1 -> 4 pops and evt_valid falls.
REQ-032 The bench SHALL cover full with pop: FIFO full, evt_ready=1 on the cycle a new event arrives -> occupancy stays 4, overflow=0.
REQ-033 The bench SHALL cover reset release: cnt_in=8'h00 on the first edge after reset, prev forced from 8'hFF -> no record; wraps=0.
REQ-034 The bench SHALL cover reset mid-queue: 3 records queued, rst pulsed 1 cycle -> evt_valid=0, wraps=0, overflow=0, and the next event is stored at entry 0.
